// File: rtl/sale_terminal_ctrl.sv
// Top-level sequencer for the sale terminal: turns key/select pulses and mode switches into
// registered one-cycle command pulses for the barcode register, highlight block and basket.
module sale_terminal_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int ID_W            = 4,
    parameter int QTY_W           = 4,
    parameter int BASKET_DEPTH    = 16,
    parameter int ERR_HOLD_CYCLES = 25_000_000,
    parameter int END_HOLD_CYCLES = 50_000_000
) (
    input  logic                              CLOCK_50,
    input  logic                              RESET_N,
    input  logic [NUM_KEYS-1:0]               KEY_Pulse,
    input  logic                              SEL_Pulse,
    input  logic [1:0]                        CleanSW,
    input  logic                              BarcodeDigitCompleted,
    input  logic                              Product_valid,
    input  logic [ID_W-1:0]                   ProductID_Barcode,
    input  logic [ID_W-1:0]                   ProductID_Dir,
    input  logic [$clog2(BASKET_DEPTH+1)-1:0] BasketProductNum,
    output logic [2:0]                        State,
    output logic                              Barcode_Enable_Pulse,
    output logic                              Barcode_Clear_Pulse,
    output logic [3:0]                        Barcode_Digit_out,
    output logic                              Dir_En_Pulse,
    output logic                              Dir_Clear_Pulse,
    output logic [1:0]                        Dir_out,
    output logic                              Basket_Add_Pulse,
    output logic                              Basket_Remove_Pulse,
    output logic                              Basket_Clear_Pulse,
    output logic [ID_W-1:0]                   ProductID_out,
    output logic [QTY_W-1:0]                  ProductQuantity,
    output logic                              Err_Flag
);
    localparam int NUM_W    = $clog2(BASKET_DEPTH + 1);
    localparam int KIDX_W   = $clog2(NUM_KEYS);
    localparam int HOLD_MAX = (ERR_HOLD_CYCLES > END_HOLD_CYCLES) ? ERR_HOLD_CYCLES : END_HOLD_CYCLES;
    localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(ERR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] END_LAST = CNT_W'(END_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_IDLE    = 3'd1,
        S_BARCODE = 3'd2,
        S_INTER   = 3'd3,
        S_QTY     = 3'd4,
        S_EDIT    = 3'd5,
        S_END     = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t            state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              bar_en_r, bar_en_s, bar_clr_r, bar_clr_s;
    logic              dir_en_r, dir_en_s, dir_clr_r, dir_clr_s;
    logic              bsk_add_r, bsk_add_s, bsk_rem_r, bsk_rem_s, bsk_clr_r, bsk_clr_s;
    logic              err_r, err_s;
    logic [3:0]        digit_r, digit_next_s;
    logic [1:0]        dir_r, dir_next_s;
    logic [ID_W-1:0]   pid_r, pid_next_s;
    logic [QTY_W-1:0]  qty_r, qty_next_s;

    logic              key_onehot_s, key_valid_s, dir_valid_s, full_s;
    logic [KIDX_W-1:0] key_idx_s;
    logic [3:0]        key_digit_s;
    logic [QTY_W-1:0]  key_qty_s;
    logic [1:0]        key_dir_s;

    // One-hot key decode; a select in the same cycle masks every key
    always_comb begin
        key_idx_s    = '0;
        key_onehot_s = (KEY_Pulse != '0) &&
                       ((KEY_Pulse & (KEY_Pulse - NUM_KEYS'(1'b1))) == '0);
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_idx_s = KEY_Pulse[i] ? KIDX_W'(i) : key_idx_s;
        end
        key_valid_s = key_onehot_s && !SEL_Pulse;
        dir_valid_s = key_valid_s && (int'(key_idx_s) < 32'sd4);
        key_digit_s = 4'(NUM_KEYS - int'(key_idx_s));
        key_qty_s   = QTY_W'(int'(key_idx_s) + 32'sd1);
        key_dir_s   = ~key_idx_s[1:0];
        full_s      = (BasketProductNum >= NUM_W'(BASKET_DEPTH));
    end

    // Next-state and next-output decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = '0;
        bar_en_s     = 1'b0;
        bar_clr_s    = 1'b0;
        dir_en_s     = 1'b0;
        dir_clr_s    = 1'b0;
        bsk_add_s    = 1'b0;
        bsk_rem_s    = 1'b0;
        bsk_clr_s    = 1'b0;
        digit_next_s = digit_r;
        dir_next_s   = dir_r;
        pid_next_s   = pid_r;
        qty_next_s   = qty_r;
        case (state_r)
            S_START: begin
                bar_clr_s    = 1'b1;
                dir_clr_s    = 1'b1;
                bsk_clr_s    = 1'b1;
                state_next_s = S_IDLE;
            end
            S_IDLE: begin
                if (SEL_Pulse) begin
                    state_next_s = S_END;
                end else if (CleanSW[0]) begin
                    bar_clr_s    = 1'b1;
                    dir_clr_s    = 1'b1;
                    state_next_s = S_EDIT;
                end else if (CleanSW[1]) begin
                    bar_clr_s    = 1'b1;
                    dir_clr_s    = 1'b1;
                    state_next_s = S_INTER;
                end else begin
                    state_next_s = S_BARCODE;
                end
            end
            S_BARCODE: begin
                if (CleanSW != 2'b00) begin
                    bar_clr_s    = 1'b1;
                    state_next_s = S_IDLE;
                end else if (!BarcodeDigitCompleted) begin
                    bar_en_s     = key_valid_s;
                    digit_next_s = key_valid_s ? key_digit_s : digit_r;
                end else if (SEL_Pulse) begin
                    bar_clr_s = 1'b1;
                    if (Product_valid && !full_s) begin
                        pid_next_s   = ProductID_Barcode;
                        state_next_s = S_QTY;
                    end else begin
                        state_next_s = S_ERROR;
                    end
                end else begin
                    state_next_s = S_BARCODE;
                end
            end
            S_INTER: begin
                if (!CleanSW[1] || CleanSW[0]) begin
                    state_next_s = S_IDLE;
                end else if (SEL_Pulse) begin
                    if (!full_s) begin
                        pid_next_s   = ProductID_Dir;
                        dir_clr_s    = 1'b1;
                        state_next_s = S_QTY;
                    end else begin
                        state_next_s = S_ERROR;
                    end
                end else begin
                    dir_en_s   = dir_valid_s;
                    dir_next_s = dir_valid_s ? key_dir_s : dir_r;
                end
            end
            S_QTY: begin
                if (SEL_Pulse) begin
                    state_next_s = S_IDLE;
                end else if (key_valid_s) begin
                    qty_next_s   = key_qty_s;
                    bsk_add_s    = 1'b1;
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_QTY;
                end
            end
            S_EDIT: begin
                if (!CleanSW[0]) begin
                    dir_clr_s    = 1'b1;
                    state_next_s = S_IDLE;
                end else if (SEL_Pulse) begin
                    if (BasketProductNum != '0) begin
                        pid_next_s = ProductID_Dir;
                        bsk_rem_s  = 1'b1;
                    end else begin
                        state_next_s = S_ERROR;
                    end
                end else begin
                    dir_en_s   = dir_valid_s;
                    dir_next_s = dir_valid_s ? key_dir_s : dir_r;
                end
            end
            S_END: begin
                if (cnt_r == END_LAST) begin
                    state_next_s = S_START;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1'b1);
                end
            end
            S_ERROR: begin
                if (cnt_r == ERR_LAST) begin
                    state_next_s = S_IDLE;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_next_s = S_START;
            end
        endcase
        err_s = (state_next_s == S_ERROR);
    end

    // State, hold counter and registered outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= S_START;
            cnt_r     <= '0;
            bar_en_r  <= 1'b0;
            bar_clr_r <= 1'b0;
            dir_en_r  <= 1'b0;
            dir_clr_r <= 1'b0;
            bsk_add_r <= 1'b0;
            bsk_rem_r <= 1'b0;
            bsk_clr_r <= 1'b0;
            err_r     <= 1'b0;
            digit_r   <= 4'd0;
            dir_r     <= 2'd0;
            pid_r     <= '0;
            qty_r     <= '0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            bar_en_r  <= bar_en_s;
            bar_clr_r <= bar_clr_s;
            dir_en_r  <= dir_en_s;
            dir_clr_r <= dir_clr_s;
            bsk_add_r <= bsk_add_s;
            bsk_rem_r <= bsk_rem_s;
            bsk_clr_r <= bsk_clr_s;
            err_r     <= err_s;
            digit_r   <= digit_next_s;
            dir_r     <= dir_next_s;
            pid_r     <= pid_next_s;
            qty_r     <= qty_next_s;
        end
    end

    assign State                = state_r;
    assign Barcode_Enable_Pulse = bar_en_r;
    assign Barcode_Clear_Pulse  = bar_clr_r;
    assign Barcode_Digit_out    = digit_r;
    assign Dir_En_Pulse         = dir_en_r;
    assign Dir_Clear_Pulse      = dir_clr_r;
    assign Dir_out              = dir_r;
    assign Basket_Add_Pulse     = bsk_add_r;
    assign Basket_Remove_Pulse  = bsk_rem_r;
    assign Basket_Clear_Pulse   = bsk_clr_r;
    assign ProductID_out        = pid_r;
    assign ProductQuantity      = qty_r;
    assign Err_Flag             = err_r;
endmodule

// File: tb/tb_sale_terminal_ctrl.sv
// Bench for sale_terminal_ctrl: directed scenarios then random traffic, every cycle compared
// against a behavioural model of the terminal's rules.
module tb_sale_terminal_ctrl;
    localparam int NUM_KEYS = 4;
    localparam int ID_W     = 4;
    localparam int QTY_W    = 4;
    localparam int DEPTH    = 16;
    localparam int ERR_HOLD = 3;
    localparam int END_HOLD = 4;
    localparam int NUM_W    = $clog2(DEPTH + 1);
    localparam int ST_START = 0, ST_IDLE = 1, ST_BARCODE = 2, ST_INTER = 3;
    localparam int ST_QTY = 4, ST_EDIT = 5, ST_END = 6, ST_ERROR = 7;

    logic CLOCK_50 = 1'b0;
    logic RESET_N;
    logic [NUM_KEYS-1:0] key_s;
    logic sel_s;
    logic [1:0] sw_s;
    logic done_s, valid_s;
    logic [ID_W-1:0] pidb_s, pidd_s;
    logic [NUM_W-1:0] num_s;

    logic [2:0] State;
    logic Barcode_Enable_Pulse, Barcode_Clear_Pulse, Dir_En_Pulse, Dir_Clear_Pulse;
    logic Basket_Add_Pulse, Basket_Remove_Pulse, Basket_Clear_Pulse, Err_Flag;
    logic [3:0] Barcode_Digit_out;
    logic [1:0] Dir_out;
    logic [ID_W-1:0] ProductID_out;
    logic [QTY_W-1:0] ProductQuantity;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model of the terminal
    int m_state, m_hold;
    logic m_bep, m_bcp, m_dep, m_dcp, m_bap, m_brp, m_bclp;
    logic [3:0] m_digit;
    logic [1:0] m_dir;
    logic [ID_W-1:0] m_pid;
    logic [QTY_W-1:0] m_qty;

    sale_terminal_ctrl #(
        .NUM_KEYS(NUM_KEYS), .ID_W(ID_W), .QTY_W(QTY_W), .BASKET_DEPTH(DEPTH),
        .ERR_HOLD_CYCLES(ERR_HOLD), .END_HOLD_CYCLES(END_HOLD)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY_Pulse(key_s), .SEL_Pulse(sel_s),
        .CleanSW(sw_s), .BarcodeDigitCompleted(done_s), .Product_valid(valid_s),
        .ProductID_Barcode(pidb_s), .ProductID_Dir(pidd_s), .BasketProductNum(num_s),
        .State(State), .Barcode_Enable_Pulse(Barcode_Enable_Pulse),
        .Barcode_Clear_Pulse(Barcode_Clear_Pulse), .Barcode_Digit_out(Barcode_Digit_out),
        .Dir_En_Pulse(Dir_En_Pulse), .Dir_Clear_Pulse(Dir_Clear_Pulse), .Dir_out(Dir_out),
        .Basket_Add_Pulse(Basket_Add_Pulse), .Basket_Remove_Pulse(Basket_Remove_Pulse),
        .Basket_Clear_Pulse(Basket_Clear_Pulse), .ProductID_out(ProductID_out),
        .ProductQuantity(ProductQuantity), .Err_Flag(Err_Flag)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] obs_vec();
        return 32'({State, Barcode_Enable_Pulse, Barcode_Clear_Pulse, Barcode_Digit_out,
                    Dir_En_Pulse, Dir_Clear_Pulse, Dir_out, Basket_Add_Pulse,
                    Basket_Remove_Pulse, Basket_Clear_Pulse, ProductID_out,
                    ProductQuantity, Err_Flag});
    endfunction

    function automatic logic [31:0] exp_vec();
        return 32'({3'(m_state), m_bep, m_bcp, m_digit, m_dep, m_dcp, m_dir, m_bap,
                    m_brp, m_bclp, m_pid, m_qty, (m_state == ST_ERROR)});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_START; m_hold = 0;
        {m_bep, m_bcp, m_dep, m_dcp, m_bap, m_brp, m_bclp} = 7'd0;
        m_digit = 4'd0; m_dir = 2'd0; m_pid = '0; m_qty = '0;
    endtask

    // one clock of the terminal rules, applied to the inputs currently driven
    task automatic model_step();
        int k, ones, nxt;
        bit full;
        {m_bep, m_bcp, m_dep, m_dcp, m_bap, m_brp, m_bclp} = 7'd0;
        k = -1; ones = 0;
        for (int i = 0; i < NUM_KEYS; i++) if (key_s[i]) begin ones++; k = i; end
        if (ones != 1 || sel_s) k = -1;
        full = (int'(num_s) == DEPTH);
        nxt = m_state;
        case (m_state)
            ST_START: begin m_bcp = 1; m_dcp = 1; m_bclp = 1; nxt = ST_IDLE; end
            ST_IDLE:
                if (sel_s) nxt = ST_END;
                else if (sw_s[0]) begin nxt = ST_EDIT; m_bcp = 1; m_dcp = 1; end
                else if (sw_s[1]) begin nxt = ST_INTER; m_bcp = 1; m_dcp = 1; end
                else nxt = ST_BARCODE;
            ST_BARCODE:
                if (sw_s != 2'b00) begin nxt = ST_IDLE; m_bcp = 1; end
                else if (!done_s) begin
                    if (k >= 0) begin m_bep = 1; m_digit = 4'(NUM_KEYS - k); end
                end else if (sel_s) begin
                    m_bcp = 1;
                    if (valid_s && !full) begin m_pid = pidb_s; nxt = ST_QTY; end
                    else nxt = ST_ERROR;
                end
            ST_INTER:
                if (!sw_s[1] || sw_s[0]) nxt = ST_IDLE;
                else if (sel_s) begin
                    if (!full) begin m_pid = pidd_s; m_dcp = 1; nxt = ST_QTY; end
                    else nxt = ST_ERROR;
                end else if (k >= 0 && k < 4) begin m_dep = 1; m_dir = 2'(3 - k); end
            ST_QTY:
                if (sel_s) nxt = ST_IDLE;
                else if (k >= 0) begin m_qty = QTY_W'(k + 1); m_bap = 1; nxt = ST_IDLE; end
            ST_EDIT:
                if (!sw_s[0]) begin nxt = ST_IDLE; m_dcp = 1; end
                else if (sel_s) begin
                    if (num_s != 0) begin m_pid = pidd_s; m_brp = 1; end
                    else nxt = ST_ERROR;
                end else if (k >= 0 && k < 4) begin m_dep = 1; m_dir = 2'(3 - k); end
            ST_END: begin m_hold--; if (m_hold == 0) nxt = ST_START; end
            ST_ERROR: begin m_hold--; if (m_hold == 0) nxt = ST_IDLE; end
            default: nxt = ST_START;
        endcase
        if (nxt != m_state && nxt == ST_END) m_hold = END_HOLD;
        if (nxt != m_state && nxt == ST_ERROR) m_hold = ERR_HOLD;
        m_state = nxt;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge CLOCK_50); #1;
        cyc++;
        chk(tag, obs_vec(), exp_vec());
    endtask

    task automatic drive(input logic [NUM_KEYS-1:0] k, input logic s, input logic [1:0] w,
                         input string tag);
        key_s = k; sel_s = s; sw_s = w;
        tick(tag);
        key_s = '0; sel_s = 1'b0;
    endtask

    initial begin
        int err_cnt, r;
        RESET_N = 1'b0; key_s = '0; sel_s = 1'b0; sw_s = 2'b00; done_s = 1'b0;
        valid_s = 1'b0; pidb_s = '0; pidd_s = '0; num_s = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_state", obs_vec(), 32'd0);
        model_reset();
        RESET_N = 1'b1;

        drive(4'b0000, 1'b0, 2'b00, "start");
        chk("start_clears", 32'({State, Barcode_Clear_Pulse, Dir_Clear_Pulse, Basket_Clear_Pulse}),
            32'({3'd1, 3'b111}));
        drive(4'b0000, 1'b0, 2'b00, "to_barcode");
        drive(4'b0000, 1'b0, 2'b00, "barcode_quiet");

        drive(4'b1000, 1'b0, 2'b00, "digit1");
        drive(4'b0100, 1'b0, 2'b00, "digit2");
        drive(4'b0010, 1'b0, 2'b00, "digit3");
        drive(4'b0001, 1'b0, 2'b00, "digit4");
        chk("digit4_direct", 32'({Barcode_Enable_Pulse, Barcode_Digit_out}), 32'({1'b1, 4'd4}));
        done_s = 1'b1; valid_s = 1'b1; pidb_s = 4'd9; num_s = NUM_W'(3);
        drive(4'b0000, 1'b1, 2'b00, "bc_sel_qty");
        drive(4'b0010, 1'b0, 2'b00, "qty_add");
        chk("add_direct", 32'({State, Basket_Add_Pulse, ProductQuantity, ProductID_out}),
            32'({3'd1, 1'b1, 4'd2, 4'd9}));

        drive(4'b0000, 1'b0, 2'b00, "to_barcode2");
        valid_s = 1'b0;
        drive(4'b0000, 1'b1, 2'b00, "bc_invalid");
        chk("invalid_clear", 32'({Barcode_Clear_Pulse, Err_Flag}), 32'({1'b1, 1'b1}));
        err_cnt = Err_Flag ? 1 : 0;
        for (int i = 0; i < 10 && Err_Flag; i++) begin
            drive(4'b0000, 1'b0, 2'b00, "err_wait");
            if (Err_Flag) err_cnt++;
        end
        chk("err_hold_len", 32'(err_cnt), 32'(ERR_HOLD));

        done_s = 1'b0; num_s = NUM_W'(DEPTH);
        drive(4'b0000, 1'b0, 2'b10, "to_inter");
        drive(4'b0001, 1'b0, 2'b10, "inter_dir");
        drive(4'b0000, 1'b1, 2'b10, "inter_full");
        chk("full_no_add", 32'({State, Basket_Add_Pulse}), 32'({3'd7, 1'b0}));
        repeat (ERR_HOLD) drive(4'b0000, 1'b0, 2'b10, "err_wait2");
        num_s = NUM_W'(2); pidd_s = 4'd5;
        drive(4'b0000, 1'b0, 2'b10, "to_inter2");
        drive(4'b0100, 1'b1, 2'b10, "inter_sel_key");
        chk("sel_drops_key", 32'({State, Dir_En_Pulse, ProductID_out}), 32'({3'd4, 1'b0, 4'd5}));
        drive(4'b0001, 1'b1, 2'b10, "qty_abort");
        chk("abort_no_add", 32'({State, Basket_Add_Pulse}), 32'({3'd1, 1'b0}));
        drive(4'b0000, 1'b0, 2'b10, "to_inter3");
        drive(4'b0000, 1'b0, 2'b00, "inter_exit");

        drive(4'b0000, 1'b0, 2'b01, "to_edit");
        drive(4'b0001, 1'b0, 2'b01, "edit_dir");
        chk("edit_dir_direct", 32'({Dir_En_Pulse, Dir_out}), 32'({1'b1, 2'b11}));
        num_s = NUM_W'(5); pidd_s = 4'd7;
        drive(4'b0000, 1'b1, 2'b01, "edit_remove");
        chk("remove_direct", 32'({State, Basket_Remove_Pulse, ProductID_out}),
            32'({3'd5, 1'b1, 4'd7}));
        num_s = '0;
        drive(4'b0000, 1'b1, 2'b01, "edit_empty");
        repeat (ERR_HOLD) drive(4'b0000, 1'b0, 2'b00, "err_wait3");

        drive(4'b0000, 1'b1, 2'b00, "idle_end");
        repeat (END_HOLD) drive(4'b0000, 1'b0, 2'b00, "end_wait");
        chk("end_to_start", 32'(State), 32'd0);
        drive(4'b0000, 1'b0, 2'b00, "restart");
        chk("restart_clear", 32'({State, Basket_Clear_Pulse}), 32'({3'd1, 1'b1}));

        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) key_s = '0;
            else if (r < 9) key_s = 4'(1 << $urandom_range(0, 3));
            else key_s = 4'($urandom);
            sel_s = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) sw_s = 2'($urandom);
            done_s = 1'($urandom);
            valid_s = ($urandom_range(0, 3) != 0);
            pidb_s = 4'($urandom);
            pidd_s = 4'($urandom);
            case ($urandom_range(0, 3))
                0: num_s = NUM_W'(0);
                1: num_s = NUM_W'(5);
                2: num_s = NUM_W'(DEPTH - 1);
                default: num_s = NUM_W'(DEPTH);
            endcase
            tick("random");
        end

        key_s = '0; sel_s = 1'b0; sw_s = 2'b00;
        for (int i = 0; i < 20 && m_state != ST_BARCODE; i++)
            drive(4'b0000, (m_state == ST_QTY), 2'b00, "seek_barcode");
        chk("reached_barcode", 32'(State), 32'(ST_BARCODE));
        done_s = 1'b1; valid_s = 1'b1; num_s = '0;
        drive(4'b0000, 1'b1, 2'b00, "to_qty");
        chk("in_qty", 32'(State), 32'd4);
        #3;
        RESET_N = 1'b0; key_s = 4'b0001;
        #1;
        chk("async_reset", obs_vec(), 32'd0);
        @(posedge CLOCK_50); #1;
        chk("reset_no_pulse", obs_vec(), 32'd0);
        key_s = '0;
        model_reset();
        RESET_N = 1'b1;
        drive(4'b0000, 1'b0, 2'b00, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
